mem_bus_arbiter: RTL and testbench
==================================

// Module: mem_bus_arbiter
// PURPOSE
//  Shares the single SRAM-like memory bus between the IF (instruction) and MEM (data) requesters.
//  Sequences one transaction at a time through an address phase and a data phase.
//  Returns read data and a one-cycle done pulse to the winning requester.
//  Drives stallreq_for_axi into the pipeline stall controller, which freezes all five stages while it is high.
// PARAMETERS
//  ADDR_W    32  address width
//  DATA_W    32  data width; byte strobe width is DATA_W/8
//  ARB_MODE  0   0 = fixed priority, data wins; 1 = round-robin, last loser wins a tie
// PORTS
//  clk              in   1         single clock, rising edge
//  resetn           in   1         asynchronous, active-low reset
//  inst_req         in   1         IF read request; held until inst_done
//  inst_addr        in   ADDR_W    IF read address
//  inst_rdata       out  DATA_W    registered read data; valid while inst_done=1
//  inst_done        out  1         one-cycle completion pulse
//  data_req         in   1         MEM request; held until data_done
//  data_wr          in   1         1 = write, 0 = read
//  data_wstrb       in   DATA_W/8  byte enables for writes
//  data_addr        in   ADDR_W    MEM address
//  data_wdata       in   DATA_W    MEM write data
//  data_rdata       out  DATA_W    registered read data; valid while data_done=1
//  data_done        out  1         one-cycle completion pulse
//  bus_req          out  1         bus address-phase request
//  bus_wr/bus_wstrb/bus_addr/bus_wdata  out  1/DATA_W/8/ADDR_W/DATA_W  latched command
//  bus_addr_ok      in   1         slave accepted the address phase
//  bus_data_ok      in   1         slave completed the data phase
//  bus_rdata        in   DATA_W    slave read data; valid with bus_data_ok
//  stallreq_for_axi out  1         pipeline stall request
// BEHAVIOUR
//  Reset: every output and register is 0; state=IDLE; rr_last=inst.
//  Reset asserted mid-transaction aborts it immediately. The slave is reset together with this block.
//  States:
//   IDLE: if any req, grant per ARB_MODE, latch the command into bus_* registers, go to ADDR.
//   ADDR: bus_req=1 with a stable command; on bus_addr_ok go to DATA. bus_data_ok is ignored here.
//   DATA: bus_req=0; on bus_data_ok latch bus_rdata into the granted rdata register, go to RESP.
//   RESP: the granted done output =1 for exactly this cycle; no new grant; go to IDLE.
//  Latency with zero-wait slave: req at cycle 0 -> bus_req in cycle 1 -> data_ok in cycle 2 -> done in cycle 3.
//  Tie (both req in IDLE): ARB_MODE 0 grants data. ARB_MODE 1 grants the requester not granted last (rr_last).
//  A writes the latched wstrb/wdata to the bus. Its done pulse still occurs, and data_rdata holds its previous value.
//  bus_addr_ok or bus_data_ok outside its phase is ignored with no state change.
//  stallreq_for_axi = (inst_req & ~inst_done) | (data_req & ~data_done). Combinational from inputs and registered done.
//  A requester dropping req mid-transaction does not cancel the transaction. Its done pulse is still generated.
//  rdata registers keep their value until the next completion for the same requester.
// STRUCTURE
//  State encodings (IDLE/ADDR/DATA/RESP, 2 bits), the grant id, and the bus-command width macro go in lib/defines.vh.
//  One sub-module, mem_arb_grant: combinational grant plus the rr_last flop, parameterised by ARB_MODE.
//  The FSM, command latches and rdata registers live in the top module.
// TESTING
//  1. Single inst read at 0x1FC0_0000, slave with zero wait, rdata=0x2402_0001:
//     bus_req cycle 1, inst_done cycle 3, inst_rdata=0x2402_0001, stall high in cycles 0-2 and low in cycle 3.
//  2. inst_req and data_req (read) together, ARB_MODE=0: data served first, then inst.
//     Exactly two bus_req phases; done pulses in order data then inst.
//  3. ARB_MODE=1, both requesters held high for 4 transactions: grants alternate data, inst, data, inst.
//     The first grant follows rr_last=inst.
//  4. Write wstrb=4'b0011, wdata=0xDEAD_BEEF, addr_ok delayed 3 cycles:
//     bus_* stable while bus_req=1; data_done fires once; data_rdata unchanged.
//  5. Spurious bus_data_ok pulse in IDLE and in ADDR: no state change, no done pulse.
//  6. resetn low during DATA: all outputs 0 at once; after release, a fresh inst request completes normally.

Source files
------------

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the IF/MEM memory bus arbiter: FSM states, requester ids
// and the width of the latched bus command {wr, wstrb, addr, wdata}.
package mem_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_RESP = 2'd3
    } arb_state_e;

    typedef enum logic {
        GNT_INST = 1'b0,
        GNT_DATA = 1'b1
    } grant_e;

    function automatic int busCmdWidth(input int addrW, input int dataW);
        return 1 + dataW / 8 + addrW + dataW;
    endfunction

endpackage

// File: rtl/mem_arb_grant.sv
// Grant decision between the instruction and data requesters, plus the flop
// remembering who won last so round-robin mode can favour the other side.
module mem_arb_grant
    import mem_bus_arbiter_pkg::*;
#(
    parameter int ARB_MODE = 0
) (
    input  logic   clk,
    input  logic   resetn,
    input  logic   i_instReq,
    input  logic   i_dataReq,
    input  logic   i_grantEn,
    output grant_e o_grant,
    output logic   o_anyReq
);

    grant_e r_rrLast;

    assign o_anyReq = i_instReq | i_dataReq;

    // On a tie, mode 0 always favours data; mode 1 favours whoever was not granted last.
    always_comb begin
        o_grant = GNT_INST;
        if (i_dataReq && !i_instReq) begin
            o_grant = GNT_DATA;
        end else if (i_dataReq && i_instReq) begin
            if (ARB_MODE == 0) begin
                o_grant = GNT_DATA;
            end else begin
                o_grant = (r_rrLast == GNT_INST) ? GNT_DATA : GNT_INST;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rrLast <= GNT_INST;
        end else if (i_grantEn) begin
            r_rrLast <= o_grant;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one SRAM-like bus between the IF and MEM requesters, one transaction at a
// time through address and data phases, and raises the pipeline stall meanwhile.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int ARB_MODE = 0
) (
    input  logic                  clk,
    input  logic                  resetn,

    input  logic                  inst_req,
    input  logic [ADDR_W-1:0]     inst_addr,
    output logic [DATA_W-1:0]     inst_rdata,
    output logic                  inst_done,

    input  logic                  data_req,
    input  logic                  data_wr,
    input  logic [DATA_W/8-1:0]   data_wstrb,
    input  logic [ADDR_W-1:0]     data_addr,
    input  logic [DATA_W-1:0]     data_wdata,
    output logic [DATA_W-1:0]     data_rdata,
    output logic                  data_done,

    output logic                  bus_req,
    output logic                  bus_wr,
    output logic [DATA_W/8-1:0]   bus_wstrb,
    output logic [ADDR_W-1:0]     bus_addr,
    output logic [DATA_W-1:0]     bus_wdata,
    input  logic                  bus_addr_ok,
    input  logic                  bus_data_ok,
    input  logic [DATA_W-1:0]     bus_rdata,

    output logic                  stallreq_for_axi
);

    localparam int STRB_W = DATA_W / 8;
    localparam int CMD_W  = busCmdWidth(ADDR_W, DATA_W);

    arb_state_e         r_state;
    arb_state_e         w_nextState;
    grant_e             r_grant;
    grant_e             w_grant;
    logic               w_anyReq;
    logic               w_grantEn;
    logic               w_rdataEn;
    logic [CMD_W-1:0]   r_cmd;
    logic [CMD_W-1:0]   w_cmdNext;
    logic [DATA_W-1:0]  r_instRdata;
    logic [DATA_W-1:0]  r_dataRdata;

    mem_arb_grant #(
        .ARB_MODE (ARB_MODE)
    ) u_grant (
        .clk       (clk),
        .resetn    (resetn),
        .i_instReq (inst_req),
        .i_dataReq (data_req),
        .i_grantEn (w_grantEn),
        .o_grant   (w_grant),
        .o_anyReq  (w_anyReq)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Phase acknowledges are only honoured in their own state; anything else is ignored.
    always_comb begin
        w_nextState = r_state;
        w_grantEn   = 1'b0;
        w_rdataEn   = 1'b0;
        bus_req     = 1'b0;
        inst_done   = 1'b0;
        data_done   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_anyReq) begin
                    w_grantEn   = 1'b1;
                    w_nextState = ST_ADDR;
                end
            end
            ST_ADDR: begin
                bus_req = 1'b1;
                if (bus_addr_ok) begin
                    w_nextState = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bus_data_ok) begin
                    w_rdataEn   = 1'b1;
                    w_nextState = ST_RESP;
                end
            end
            ST_RESP: begin
                inst_done   = (r_grant == GNT_INST);
                data_done   = (r_grant == GNT_DATA);
                w_nextState = ST_IDLE;
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    // Instruction fetches are always reads, so their write fields are cleared.
    always_comb begin
        if (w_grant == GNT_DATA) begin
            w_cmdNext = {data_wr, data_wstrb, data_addr, data_wdata};
        end else begin
            w_cmdNext = {1'b0, {STRB_W{1'b0}}, inst_addr, {DATA_W{1'b0}}};
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_grant     <= GNT_INST;
            r_cmd       <= '0;
            r_instRdata <= '0;
            r_dataRdata <= '0;
        end else begin
            if (w_grantEn) begin
                r_grant <= w_grant;
                r_cmd   <= w_cmdNext;
            end
            if (w_rdataEn) begin
                if (r_grant == GNT_INST) begin
                    r_instRdata <= bus_rdata;
                end else if (!r_cmd[CMD_W-1]) begin
                    r_dataRdata <= bus_rdata;
                end
            end
        end
    end

    assign {bus_wr, bus_wstrb, bus_addr, bus_wdata} = r_cmd;
    assign inst_rdata       = r_instRdata;
    assign data_rdata       = r_dataRdata;
    assign stallreq_for_axi = (inst_req & ~inst_done) | (data_req & ~data_done);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: a fixed-priority instance with a switchable
// zero-wait/manual slave, and a round-robin instance with its own zero-wait slave.
module tb_mem_bus_arbiter;

    typedef struct packed {
        logic        isData;
        logic        wr;
        logic [3:0]  wstrb;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] expRdata;
        logic [7:0]  expLatency;
    } vec_t;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    logic        instReq, dataReq, dataWr;
    logic [3:0]  dataWstrb;
    logic [31:0] instAddr, dataAddr, dataWdata;
    logic [31:0] instRdata, dataRdata;
    logic        instDone, dataDone;
    logic        busReq, busWr;
    logic [3:0]  busWstrb;
    logic [31:0] busAddr, busWdata;
    logic        busAddrOk, busDataOk;
    logic [31:0] busRdata;
    logic        stall;

    logic        slaveAuto, manAddrOk, manDataOk;
    logic [31:0] manRdata;
    logic        pend;
    logic [31:0] pendAddr;

    logic        rrInstReq, rrDataReq;
    logic [31:0] rrInstAddr, rrDataAddr;
    logic [31:0] rrInstRdata, rrDataRdata;
    logic        rrInstDone, rrDataDone;
    logic        rrBusReq, rrBusWr;
    logic [3:0]  rrBusWstrb;
    logic [31:0] rrBusAddr, rrBusWdata, rrBusRdata;
    logic        rrStall;
    logic        rrPend;
    logic [31:0] rrPendAddr;

    int testsRun = 0;
    int testsFailed = 0;

    function automatic logic [31:0] slaveWord(input logic [31:0] addr);
        return addr ^ 32'h3BC2_0001;
    endfunction

    mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .ARB_MODE(0)) dut (
        .clk(clk), .resetn(resetn),
        .inst_req(instReq), .inst_addr(instAddr), .inst_rdata(instRdata), .inst_done(instDone),
        .data_req(dataReq), .data_wr(dataWr), .data_wstrb(dataWstrb), .data_addr(dataAddr),
        .data_wdata(dataWdata), .data_rdata(dataRdata), .data_done(dataDone),
        .bus_req(busReq), .bus_wr(busWr), .bus_wstrb(busWstrb), .bus_addr(busAddr),
        .bus_wdata(busWdata), .bus_addr_ok(busAddrOk), .bus_data_ok(busDataOk),
        .bus_rdata(busRdata), .stallreq_for_axi(stall)
    );

    mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .ARB_MODE(1)) dutRr (
        .clk(clk), .resetn(resetn),
        .inst_req(rrInstReq), .inst_addr(rrInstAddr), .inst_rdata(rrInstRdata), .inst_done(rrInstDone),
        .data_req(rrDataReq), .data_wr(1'b0), .data_wstrb(4'h0), .data_addr(rrDataAddr),
        .data_wdata(32'h0), .data_rdata(rrDataRdata), .data_done(rrDataDone),
        .bus_req(rrBusReq), .bus_wr(rrBusWr), .bus_wstrb(rrBusWstrb), .bus_addr(rrBusAddr),
        .bus_wdata(rrBusWdata), .bus_addr_ok(rrBusReq), .bus_data_ok(rrPend),
        .bus_rdata(rrBusRdata), .stallreq_for_axi(rrStall)
    );

    // Zero-wait slave: accepts the address immediately and answers one cycle later.
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pend     <= 1'b0;
            pendAddr <= '0;
        end else if (slaveAuto) begin
            if (pend) begin
                pend <= 1'b0;
            end else if (busReq) begin
                pend     <= 1'b1;
                pendAddr <= busAddr;
            end
        end
    end

    assign busAddrOk = slaveAuto ? busReq : manAddrOk;
    assign busDataOk = slaveAuto ? pend : manDataOk;
    assign busRdata  = slaveAuto ? (pend ? slaveWord(pendAddr) : 32'h0) : manRdata;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rrPend     <= 1'b0;
            rrPendAddr <= '0;
        end else if (rrPend) begin
            rrPend <= 1'b0;
        end else if (rrBusReq) begin
            rrPend     <= 1'b1;
            rrPendAddr <= rrBusAddr;
        end
    end

    assign rrBusRdata = rrPend ? slaveWord(rrPendAddr) : 32'h0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // One transaction on the fixed-priority instance; starts and ends at a negedge in IDLE.
    task automatic applyStimulus(input string name, input vec_t v);
        int   cyc;
        logic seen;
        instAddr  = v.addr;
        dataAddr  = v.addr;
        dataWr    = v.wr;
        dataWstrb = v.wstrb;
        dataWdata = v.wdata;
        if (v.isData) dataReq = 1'b1;
        else          instReq = 1'b1;
        #1;
        checkOutput({name, ".stall_c0"}, 32'(stall), 32'd1);
        checkOutput({name, ".busreq_c0"}, 32'(busReq), 32'd0);
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                checkOutput({name, ".busreq_c1"}, 32'(busReq), 32'd1);
                checkOutput({name, ".bus_addr"}, busAddr, v.addr);
                checkOutput({name, ".bus_wr"}, 32'(busWr), 32'(v.wr));
                if (v.wr) begin
                    checkOutput({name, ".bus_wstrb"}, 32'(busWstrb), 32'(v.wstrb));
                    checkOutput({name, ".bus_wdata"}, busWdata, v.wdata);
                end
            end
            seen = v.isData ? dataDone : instDone;
            if (!seen) checkOutput($sformatf("%s.stall_c%0d", name, cyc), 32'(stall), 32'd1);
        end
        checkOutput({name, ".latency"}, 32'(cyc), 32'(v.expLatency));
        checkOutput({name, ".rdata"}, v.isData ? dataRdata : instRdata, v.expRdata);
        checkOutput({name, ".other_done"}, 32'(v.isData ? instDone : dataDone), 32'd0);
        checkOutput({name, ".stall_done"}, 32'(stall), 32'd0);
        instReq = 1'b0;
        dataReq = 1'b0;
        dataWr  = 1'b0;
        @(negedge clk);
        checkOutput({name, ".done_cleared"}, 32'(instDone | dataDone), 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vec_t vecs[5];
        int   phases, nDone, doneCnt, doneCyc;
        logic prevBr;
        logic [7:0] doneSeq;

        vecs[0] = '{isData:1'b0, wr:1'b0, wstrb:4'h0, addr:32'h1FC0_0000, wdata:32'h0, expRdata:32'h2402_0001, expLatency:8'd3};
        vecs[1] = '{isData:1'b1, wr:1'b0, wstrb:4'h0, addr:32'h8000_1000, wdata:32'h0, expRdata:32'hBBC2_1001, expLatency:8'd3};
        vecs[2] = '{isData:1'b1, wr:1'b1, wstrb:4'h3, addr:32'h8000_2000, wdata:32'hDEAD_BEEF, expRdata:32'hBBC2_1001, expLatency:8'd3};
        vecs[3] = '{isData:1'b0, wr:1'b0, wstrb:4'h0, addr:32'h0000_0004, wdata:32'h0, expRdata:32'h3BC2_0005, expLatency:8'd3};
        vecs[4] = '{isData:1'b1, wr:1'b0, wstrb:4'h0, addr:32'hFFFF_FFFC, wdata:32'h0, expRdata:32'hC43D_FFFD, expLatency:8'd3};

        resetn = 1'b0;
        instReq = 1'b0; dataReq = 1'b0; dataWr = 1'b0; dataWstrb = 4'h0;
        instAddr = '0; dataAddr = '0; dataWdata = '0;
        slaveAuto = 1'b1; manAddrOk = 1'b0; manDataOk = 1'b0; manRdata = '0;
        rrInstReq = 1'b0; rrDataReq = 1'b0; rrInstAddr = '0; rrDataAddr = '0;
        repeat (2) @(negedge clk);

        checkOutput("reset.bus_req", 32'(busReq), 32'd0);
        checkOutput("reset.done", 32'({instDone, dataDone}), 32'd0);
        checkOutput("reset.inst_rdata", instRdata, 32'd0);
        checkOutput("reset.data_rdata", dataRdata, 32'd0);
        checkOutput("reset.bus_addr", busAddr, 32'd0);
        checkOutput("reset.stall", 32'(stall), 32'd0);
        checkOutput("reset.rr_cmd", 32'({rrBusWr, rrBusWstrb}) | rrBusWdata, 32'd0);
        resetn = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 5; i++) applyStimulus($sformatf("vec%0d", i), vecs[i]);

        // Simultaneous requests under fixed priority: data first, then inst.
        instAddr = 32'h0000_0100; dataAddr = 32'h0000_0200; dataWr = 1'b0;
        instReq = 1'b1; dataReq = 1'b1;
        phases = 0; nDone = 0; prevBr = 1'b0; doneSeq = '0;
        for (int c = 1; c <= 20 && nDone < 2; c++) begin
            @(negedge clk);
            if (busReq && !prevBr) phases++;
            prevBr = busReq;
            if (dataDone) begin doneSeq = {doneSeq[5:0], 2'b01}; nDone++; dataReq = 1'b0; end
            if (instDone) begin doneSeq = {doneSeq[5:0], 2'b10}; nDone++; instReq = 1'b0; end
        end
        instReq = 1'b0; dataReq = 1'b0;
        @(negedge clk);
        checkOutput("tie.bus_phases", 32'(phases), 32'd2);
        checkOutput("tie.done_order", 32'(doneSeq), 32'h06);
        checkOutput("tie.data_rdata", dataRdata, 32'h3BC2_0201);
        checkOutput("tie.inst_rdata", instRdata, 32'h3BC2_0101);

        // Round-robin instance with both requesters held for four transactions.
        rrInstAddr = 32'h0000_0040; rrDataAddr = 32'h0000_0080;
        rrInstReq = 1'b1; rrDataReq = 1'b1;
        nDone = 0; doneSeq = '0;
        for (int c = 1; c <= 40 && nDone < 4; c++) begin
            @(negedge clk);
            if (rrDataDone) begin doneSeq = {doneSeq[5:0], 2'b01}; nDone++; end
            if (rrInstDone) begin doneSeq = {doneSeq[5:0], 2'b10}; nDone++; end
        end
        rrInstReq = 1'b0; rrDataReq = 1'b0;
        @(negedge clk);
        checkOutput("rr.done_count", 32'(nDone), 32'd4);
        checkOutput("rr.grant_order", 32'(doneSeq), 32'h66);
        checkOutput("rr.inst_rdata", rrInstRdata, 32'h3BC2_0041);
        checkOutput("rr.data_rdata", rrDataRdata, 32'h3BC2_0081);
        checkOutput("rr.idle", 32'({rrStall, rrBusWr}), 32'd0);

        // Write with the address phase held off for three cycles.
        slaveAuto = 1'b0;
        dataAddr = 32'h8000_3000; dataWr = 1'b1; dataWstrb = 4'b0011; dataWdata = 32'hDEAD_BEEF;
        dataReq = 1'b1;
        doneCnt = 0; doneCyc = 0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c <= 4) begin
                checkOutput($sformatf("wr.bus_req_c%0d", c), 32'(busReq), 32'd1);
                checkOutput($sformatf("wr.bus_addr_c%0d", c), busAddr, 32'h8000_3000);
                checkOutput($sformatf("wr.bus_cmd_c%0d", c), 32'({busWr, busWstrb}), 32'h13);
                checkOutput($sformatf("wr.bus_wdata_c%0d", c), busWdata, 32'hDEAD_BEEF);
            end
            if (c == 5) checkOutput("wr.bus_req_c5", 32'(busReq), 32'd0);
            if (dataDone) begin doneCnt++; doneCyc = c; end
            manAddrOk = (c == 4);
            manDataOk = (c == 5);
            manRdata  = (c == 5) ? 32'h1234_5678 : 32'h0;
            if (c == 6) begin dataReq = 1'b0; dataWr = 1'b0; end
        end
        checkOutput("wr.done_count", 32'(doneCnt), 32'd1);
        checkOutput("wr.done_cycle", 32'(doneCyc), 32'd6);
        checkOutput("wr.data_rdata", dataRdata, 32'h3BC2_0201);

        // Stray acknowledges in IDLE and ADDR must change nothing.
        manDataOk = 1'b1; manRdata = 32'hFFFF_FFFF;
        @(negedge clk);
        checkOutput("spur.idle_done", 32'({instDone, dataDone}), 32'd0);
        checkOutput("spur.idle_bus_req", 32'(busReq), 32'd0);
        manDataOk = 1'b0;
        @(negedge clk);
        checkOutput("spur.idle_inst_rdata", instRdata, 32'h3BC2_0101);
        checkOutput("spur.idle_data_rdata", dataRdata, 32'h3BC2_0201);
        instAddr = 32'h0000_2000; instReq = 1'b1;
        @(negedge clk);
        checkOutput("spur.addr_c1", 32'(busReq), 32'd1);
        manDataOk = 1'b1; manRdata = 32'hBAD0_BAD0;
        @(negedge clk);
        checkOutput("spur.addr_hold", 32'(busReq), 32'd1);
        checkOutput("spur.addr_done", 32'({instDone, dataDone}), 32'd0);
        manDataOk = 1'b0; manAddrOk = 1'b1;
        @(negedge clk);
        checkOutput("spur.data_phase", 32'(busReq), 32'd0);
        manAddrOk = 1'b0; manDataOk = 1'b1; manRdata = 32'h0000_5A5A;
        @(negedge clk);
        checkOutput("spur.inst_done", 32'(instDone), 32'd1);
        checkOutput("spur.inst_rdata", instRdata, 32'h0000_5A5A);
        manDataOk = 1'b0; instReq = 1'b0;
        @(negedge clk);

        // Reset during the data phase, then a fresh fetch.
        instAddr = 32'h0000_3000; instReq = 1'b1;
        @(negedge clk);
        checkOutput("rst.addr_phase", 32'(busReq), 32'd1);
        manAddrOk = 1'b1;
        @(negedge clk);
        checkOutput("rst.data_phase", 32'(busReq), 32'd0);
        manAddrOk = 1'b0;
        resetn = 1'b0; instReq = 1'b0;
        #1;
        checkOutput("rst.done", 32'({instDone, dataDone}), 32'd0);
        checkOutput("rst.inst_rdata", instRdata, 32'd0);
        checkOutput("rst.data_rdata", dataRdata, 32'd0);
        checkOutput("rst.bus_addr", busAddr, 32'd0);
        checkOutput("rst.bus_cmd", 32'({busReq, busWr, busWstrb}) | busWdata, 32'd0);
        checkOutput("rst.stall", 32'(stall), 32'd0);
        checkOutput("rst.rr_rdata", rrInstRdata | rrDataRdata, 32'd0);
        @(negedge clk);
        resetn = 1'b1; slaveAuto = 1'b1;
        @(negedge clk);
        applyStimulus("post_reset", '{isData:1'b0, wr:1'b0, wstrb:4'h0, addr:32'h1FC0_0100,
                                      wdata:32'h0, expRdata:32'h2402_0101, expLatency:8'd3});

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
